// File: rtl/ins_cache_pkg.sv
// Shared types, constants and address-field width helpers for the
// set-associative RV32I instruction cache.
package ins_cache_pkg;

  typedef enum logic {
    LOOKUP = 1'b0,
    REFILL = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned ram_bits,
                                        input int unsigned sets,
                                        input int unsigned line_words);
    return ram_bits - 2 - idx_w(sets) - off_w(line_words);
  endfunction

  // Zero-width fields (Sets=1, Ways=1) still need a 1-bit carrier signal.
  function automatic int unsigned safe_w(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ins_cache_way.sv
// One cache way: per-set valid bit, tag and line data, with a combinational
// lookup port and a single refill write port.
module ins_cache_way
  import ins_cache_pkg::*;
#(
  parameter int unsigned dataW     = 32,
  parameter int unsigned Sets      = 8,
  parameter int unsigned LineWords = 4,
  parameter int unsigned TagW      = 9,
  localparam int unsigned IdxAW    = safe_w(idx_w(Sets)),
  localparam int unsigned OffW     = off_w(LineWords)
) (
  input  logic             clock,
  input  logic             clr_all_i,
  input  logic [IdxAW-1:0] rd_idx_i,
  input  logic [TagW-1:0]  rd_tag_i,
  input  logic [OffW-1:0]  rd_off_i,
  output logic             hit_o,
  output logic             valid_o,
  output logic [dataW-1:0] word_o,
  input  logic             wr_en_i,
  input  logic [IdxAW-1:0] wr_idx_i,
  input  logic [OffW-1:0]  wr_off_i,
  input  logic [dataW-1:0] wr_data_i,
  input  logic             inval_i,
  input  logic             fill_i,
  input  logic [TagW-1:0]  fill_tag_i
);

  logic [Sets-1:0]  valid_q;
  logic [TagW-1:0]  tag_q  [Sets];
  logic [dataW-1:0] data_q [Sets][LineWords];

  always_ff @(posedge clock) begin
    if (clr_all_i) begin
      valid_q <= '0;
    end else if (inval_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end else if (fill_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_i) begin
      tag_q[wr_idx_i] <= fill_tag_i;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
  end

  assign valid_o = valid_q[rd_idx_i];
  assign hit_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign word_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/ins_cache_assoc_r32i.sv
// Set-associative instruction cache with multi-word line refill from a
// zero-delay RAM port, round-robin replacement, flush and perf counters.
module ins_cache_assoc_r32i
  import ins_cache_pkg::*;
#(
  parameter int unsigned dataW       = 32,
  parameter int unsigned RAMAddrSize = 16,
  parameter int unsigned Sets        = 8,
  parameter int unsigned Ways        = 2,
  parameter int unsigned LineWords   = 4,
  parameter int unsigned CountW      = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [dataW-1:0]       ProgAddr,
  input  logic [dataW-1:0]       InsReadInp,
  input  logic                   Flush,
  output logic                   InsCacheStall,
  output logic [RAMAddrSize-1:0] InsCacheReadAddr,
  output logic [dataW-1:0]       OutputIns,
  output logic [CountW-1:0]      HitCount,
  output logic [CountW-1:0]      MissCount
);

  localparam int unsigned OffW  = off_w(LineWords);
  localparam int unsigned IdxW  = idx_w(Sets);
  localparam int unsigned IdxAW = safe_w(IdxW);
  localparam int unsigned TagW  = tag_w(RAMAddrSize, Sets, LineWords);
  localparam int unsigned PtrW  = safe_w($clog2(Ways));
  localparam logic [OffW-1:0] LAST_OFF = OffW'(LineWords - 1);

  state_e state_q, state_d;
  logic [TagW-1:0]   tag_q;
  logic [IdxAW-1:0]  idx_q;
  logic [OffW-1:0]   cnt_q;
  logic [PtrW-1:0]   vic_q;
  logic [PtrW-1:0]   rr_q [Sets];
  logic [CountW-1:0] hit_cnt_q, miss_cnt_q;

  logic [RAMAddrSize-1:0] pa;
  logic [TagW-1:0]        lk_tag;
  logic [IdxAW-1:0]       lk_idx;
  logic [OffW-1:0]        lk_off;
  logic                   unused_addr;

  assign pa          = ProgAddr[RAMAddrSize-1:0];
  assign lk_tag      = pa[RAMAddrSize-1 -: TagW];
  assign lk_off      = pa[2 +: OffW];
  assign lk_idx      = IdxAW'((pa >> (2 + OffW)) & RAMAddrSize'(Sets - 1));
  assign unused_addr = ^{ProgAddr[dataW-1:RAMAddrSize], pa[1:0]};

  function automatic logic [RAMAddrSize-1:0] line_addr(input logic [TagW-1:0]  t,
                                                       input logic [IdxAW-1:0] i,
                                                       input logic [OffW-1:0]  o);
    return (RAMAddrSize'(t) << (2 + OffW + IdxW)) |
           (RAMAddrSize'(i) << (2 + OffW)) |
           (RAMAddrSize'(o) << 2);
  endfunction

  logic [Ways-1:0]  hit_w, valid_w, wr_en;
  logic [dataW-1:0] word_w [Ways];
  logic             hit, found;
  logic [dataW-1:0] hit_word;
  logic [PtrW-1:0]  victim;
  logic             start, refill_wr, fill_done;
  logic [IdxAW-1:0] wr_idx;
  logic [OffW-1:0]  wr_off;

  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int unsigned i = 0; i < Ways; i++) begin
      if (hit_w[i]) begin
        hit      = 1'b1;
        hit_word = word_w[i];
      end
    end
  end

  // Fill empty ways first; only fall back to round-robin once the set is full.
  always_comb begin
    victim = rr_q[lk_idx];
    found  = 1'b0;
    for (int unsigned i = 0; i < Ways; i++) begin
      if (!valid_w[i] && !found) begin
        victim = PtrW'(i);
        found  = 1'b1;
      end
    end
  end

  assign start     = (state_q == LOOKUP) && !hit && !Flush;
  assign refill_wr = (state_q == REFILL) && !Flush;
  assign fill_done = refill_wr && (cnt_q == LAST_OFF);
  assign wr_idx    = start ? lk_idx : idx_q;
  assign wr_off    = start ? '0 : cnt_q;

  for (genvar w = 0; w < Ways; w++) begin : g_way
    assign wr_en[w] = (start && (victim == PtrW'(w))) || (refill_wr && (vic_q == PtrW'(w)));

    ins_cache_way #(
      .dataW    (dataW),
      .Sets     (Sets),
      .LineWords(LineWords),
      .TagW     (TagW)
    ) u_way (
      .clock     (clock),
      .clr_all_i (reset | Flush),
      .rd_idx_i  (lk_idx),
      .rd_tag_i  (lk_tag),
      .rd_off_i  (lk_off),
      .hit_o     (hit_w[w]),
      .valid_o   (valid_w[w]),
      .word_o    (word_w[w]),
      .wr_en_i   (wr_en[w]),
      .wr_idx_i  (wr_idx),
      .wr_off_i  (wr_off),
      .wr_data_i (InsReadInp),
      .inval_i   (start && (victim == PtrW'(w))),
      .fill_i    (fill_done && (vic_q == PtrW'(w))),
      .fill_tag_i(tag_q)
    );
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= LOOKUP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOOKUP:  if (!hit) state_d = REFILL;
      REFILL:  if (cnt_q == LAST_OFF) state_d = LOOKUP;
      default: state_d = LOOKUP;
    endcase
    if (Flush) state_d = LOOKUP;
  end

  always_comb begin
    InsCacheStall    = 1'b1;
    OutputIns        = dataW'(NOP_INS);
    InsCacheReadAddr = line_addr(tag_q, idx_q, cnt_q);
    if (state_q == LOOKUP) begin
      InsCacheReadAddr = line_addr(lk_tag, lk_idx, '0);
      if (hit) begin
        InsCacheStall = 1'b0;
        OutputIns     = hit_word;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      vic_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int unsigned s = 0; s < Sets; s++) rr_q[s] <= '0;
    end else begin
      if (start) begin
        tag_q <= lk_tag;
        idx_q <= lk_idx;
        vic_q <= victim;
        cnt_q <= OffW'(1);
      end else if (refill_wr) begin
        cnt_q <= cnt_q + OffW'(1);
      end
      if (fill_done) rr_q[idx_q] <= (rr_q[idx_q] + PtrW'(1)) & PtrW'(Ways - 1);
      if ((state_q == LOOKUP) && hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (start && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_ins_cache_assoc_r32i.sv
// Scoreboard bench for the set-associative instruction cache: a 2-way/8-set
// build and a direct-mapped 1-way/4-set build share the fetch stimulus.
module tb_ins_cache_assoc_r32i;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, Flush;
  logic [31:0] ProgAddr;

  logic        stall_a, stall_b;
  logic [15:0] ra_a, ra_b;
  logic [31:0] ins_a, ins_b, ram_a, ram_b;
  logic [3:0]  hc_a, mc_a, hc_b, mc_b;

  // RAM content: each word holds its own byte address in the low half.
  assign ram_a = {16'hC0DE, ra_a};
  assign ram_b = {16'hC0DE, ra_b};

  ins_cache_assoc_r32i #(
    .dataW(32), .RAMAddrSize(16), .Sets(8), .Ways(2), .LineWords(4), .CountW(4)
  ) dut (
    .clock(clock), .reset(reset), .ProgAddr(ProgAddr), .InsReadInp(ram_a), .Flush(Flush),
    .InsCacheStall(stall_a), .InsCacheReadAddr(ra_a), .OutputIns(ins_a),
    .HitCount(hc_a), .MissCount(mc_a)
  );

  ins_cache_assoc_r32i #(
    .dataW(32), .RAMAddrSize(16), .Sets(4), .Ways(1), .LineWords(4), .CountW(4)
  ) dut_dm (
    .clock(clock), .reset(reset), .ProgAddr(ProgAddr), .InsReadInp(ram_b), .Flush(Flush),
    .InsCacheStall(stall_b), .InsCacheReadAddr(ra_b), .OutputIns(ins_b),
    .HitCount(hc_b), .MissCount(mc_b)
  );

  int          total = 0;
  int          bad = 0;
  bit          sel = 1'b0;
  logic [31:0] exp_q[$];
  logic [15:0] ra_log[$];

  logic        cur_stall;
  logic [15:0] cur_ra;
  logic [31:0] cur_ins;
  assign cur_stall = sel ? stall_b : stall_a;
  assign cur_ra    = sel ? ra_b : ra_a;
  assign cur_ins   = sel ? ins_b : ins_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every instruction delivered while a fetch is outstanding is scored.
  always @(negedge clock) begin
    if (exp_q.size() > 0 && cur_stall === 1'b0) begin
      check("scoreboard OutputIns", cur_ins, exp_q.pop_front());
    end
  end

  // Starts at a cycle boundary, ends at the boundary after the hit cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int stalls);
    int n;
    bit done;
    bit nop_ok;
    n = 0;
    done = 1'b0;
    nop_ok = 1'b1;
    ra_log.delete();
    ProgAddr = a;
    exp_q.push_back(w);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (cur_stall === 1'b0) begin
        done = 1'b1;
      end else begin
        n++;
        ra_log.push_back(cur_ra);
        if (cur_ins !== NOP) nop_ok = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL fetch timeout: addr %h still stalled after 20 cycles", a);
      exp_q.delete();
    end
    check("stall cycles", n, stalls);
    if (stalls > 0) check("NOP while stalled", 32'(nop_ok), 32'd1);
  endtask

  task automatic rst();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    Flush = 1'b0;
    ProgAddr = 32'h0;
    cycles(2);
    reset = 1'b0;

    // 1: cold miss, refill sequence, then hits within the line
    check("reset HitCount", 32'(hc_a), 32'd0);
    check("reset MissCount", 32'(mc_a), 32'd0);
    check("reset stall", 32'(stall_a), 32'd1);
    check("reset ReadAddr", 32'(ra_a), 32'h0000);
    fetch(32'h0000, 32'hC0DE0000, 4);
    check("refill addr 0", 32'(ra_log[0]), 32'h0000);
    check("refill addr 1", 32'(ra_log[1]), 32'h0004);
    check("refill addr 2", 32'(ra_log[2]), 32'h0008);
    check("refill addr 3", 32'(ra_log[3]), 32'h000C);
    fetch(32'h0008, 32'hC0DE0008, 0);
    check("t1 MissCount", 32'(mc_a), 32'd1);
    check("t1 HitCount", 32'(hc_a), 32'd2);
    fetch(32'h000C, 32'hC0DE000C, 0);

    // 2: three lines in set 0, round-robin eviction
    rst();
    fetch(32'h0000, 32'hC0DE0000, 4);
    fetch(32'h0080, 32'hC0DE0080, 4);
    fetch(32'h0100, 32'hC0DE0100, 4);
    fetch(32'h0084, 32'hC0DE0084, 0);
    fetch(32'h0000, 32'hC0DE0000, 4);
    fetch(32'h0104, 32'hC0DE0104, 0);
    check("t2 MissCount", 32'(mc_a), 32'd4);

    // 3: flush during the third refill cycle
    rst();
    fetch(32'h0000, 32'hC0DE0000, 4);
    ProgAddr = 32'h0040;
    cycles(2);
    check("t3 refill addr before flush", 32'(ra_a), 32'h0048);
    Flush = 1'b1;
    cycles(1);
    Flush = 1'b0;
    check("t3 MissCount kept", 32'(mc_a), 32'd2);
    check("t3 HitCount kept", 32'(hc_a), 32'd1);
    fetch(32'h0040, 32'hC0DE0040, 4);
    check("t3 restart addr", 32'(ra_log[0]), 32'h0040);
    fetch(32'h0000, 32'hC0DE0000, 4);

    // 4: reset in the middle of a refill
    rst();
    fetch(32'h0000, 32'hC0DE0000, 4);
    ProgAddr = 32'h0020;
    cycles(2);
    rst();
    check("t4 HitCount", 32'(hc_a), 32'd0);
    check("t4 MissCount", 32'(mc_a), 32'd0);
    check("t4 stall", 32'(stall_a), 32'd1);
    fetch(32'h0020, 32'hC0DE0020, 4);
    fetch(32'h0000, 32'hC0DE0000, 4);

    // 5: counter saturation at 4'hF
    rst();
    for (int i = 0; i < 17; i++) begin
      fetch(32'(i * 16), 32'hC0DE0000 | 32'(i * 16), 4);
      if (i == 13) check("t5 MissCount 14", 32'(mc_a), 32'd14);
      if (i == 15) check("t5 MissCount sat", 32'(mc_a), 32'd15);
    end
    check("t5 MissCount still sat", 32'(mc_a), 32'd15);
    check("t5 HitCount sat", 32'(hc_a), 32'd15);

    // 6: direct-mapped build thrashing on one index
    sel = 1'b1;
    rst();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) fetch(32'h0000, 32'hC0DE0000, 4);
      else            fetch(32'h0044, 32'hC0DE0044, 4);
    end
    check("t6 MissCount", 32'(mc_b), 32'd4);
    fetch(32'h0048, 32'hC0DE0048, 0);

    cycles(2);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ins_cache_assoc_r32i.md
Name: ins_cache_assoc_r32i

Overview:
Parametrised set-associative instruction cache for the RISC-V RV32I core. It is the successor to the direct-mapped single-word instruction cache and has the same external handshake.
- It sits between the PC (ProgAddr in, InsCacheStall out), the decoder (OutputIns) and the shared zero-delay RAM read port (InsCacheReadAddr out, InsReadInp in).
- New over the previous cache: multi-word lines, N-way associativity, round-robin replacement, a flush input for fence.i, and hit/miss performance counters.

Parameters:
dataW, 32, instruction/data word width
RAMAddrSize, 16, byte-address width of RAM; ProgAddr bits above this are ignored
Sets, 8, number of sets (power of 2, >=1)
Ways, 2, associativity (power of 2, 1..8)
LineWords, 4, words per line (power of 2, >=2)
CountW, 32, width of the performance counters

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state on the next rising edge
ProgAddr  in  dataW  byte fetch address from PC; bits [1:0] ignored
InsReadInp  in  dataW  RAM read data; combinational (zero-delay) from InsCacheReadAddr
Flush  in  1  invalidate all lines (fence.i)
InsCacheStall  out  1  PC must hold; RAM port belongs to cache this cycle
InsCacheReadAddr  out  RAMAddrSize  RAM byte address of the word being refilled
OutputIns  out  dataW  instruction to decoder
HitCount  out  CountW  saturating count of hit cycles
MissCount  out  CountW  saturating count of miss events

Behaviour:
- Address split (RAMAddrSize bits): [1:0] byte (ignored); Off = log2(LineWords) word offset; Idx = log2(Sets); Tag = remaining upper bits.
- Storage per way and set: valid bit, Tag, LineWords data words. Per set: round-robin pointer of log2(Ways) bits (0 when Ways=1).
- FSM states: LOOKUP, REFILL.
- LOOKUP, combinational:
  - Hit = some way in set Idx is valid and its tag equals Tag.
  - On hit: InsCacheStall=0 and OutputIns = that way's word at Off.
  - On miss: InsCacheStall=1 and OutputIns = 32'h00000013 (NOP), so no architectural side effects occur.
  - InsCacheReadAddr = {Tag, Idx, Off=0, 2'b00}.
- LOOKUP miss, on the clock edge:
  - Latch Tag and Idx.
  - Choose the victim: the lowest-indexed invalid way, else the set's round-robin pointer.
  - Write InsReadInp into victim word 0 and clear the victim's valid bit.
  - Set word counter = 1, go to REFILL, increment MissCount.
- REFILL:
  - InsCacheStall=1, OutputIns=NOP, InsCacheReadAddr = {latched Tag, latched Idx, counter, 2'b00}.
  - Each edge: store InsReadInp into victim word[counter], then counter++.
  - When counter = LineWords-1: write the last word, set valid, write tag, advance the set's pointer (mod Ways), return to LOOKUP.
- Miss penalty: exactly LineWords stalled cycles. The following LOOKUP cycle hits.
- HitCount increments on every LOOKUP cycle with a hit. Both counters saturate at all-ones and never wrap.
- ProgAddr is held by the PC while stalled. The cache uses only the latched Tag/Idx during REFILL.
- Flush has priority over everything except reset. On the next edge:
  - All valid bits clear and the state becomes LOOKUP.
  - An in-progress refill is abandoned and its line is left invalid.
  - Counters and round-robin pointers are unchanged.
  - A lookup in the same cycle as Flush still produces its combinational hit/miss output, but a miss does not start a refill.
- Reset (synchronous), next edge: state LOOKUP, all valid=0, pointers=0, counter=0, HitCount=MissCount=0. This applies mid-refill too. After reset the first fetch misses.
- Data arrays are not reset.
- Ways=1 degenerates to direct-mapped with no pointer logic.

Decomposition:
- Package ins_cache_pkg:
  - state enum {LOOKUP, REFILL}
  - NOP_INS = 32'h00000013
  - width helper functions for Off/Idx/Tag from the parameters
- Sub-module ins_cache_way: one way's valid/tag/data arrays, providing a read port (hit flag, word) and a refill write port. Generate it Ways times.
- The top holds the FSM, victim select, round-robin pointers and counters.

Test Plan:
1. Reset, then ProgAddr=0x0000 with RAM words 0x00..0x0C = A,B,C,D: stall for 4 cycles, InsCacheReadAddr = 0x0,0x4,0x8,0xC; the next cycle OutputIns=A with stall=0; then ProgAddr=0x8 gives C with no stall; MissCount=1, HitCount=2.
2. Default config: fetch 0x0000, 0x0080 and 0x0100 (all set 0). The third fetch evicts way 0 (round robin). Refetching 0x0080 hits, and refetching 0x0000 misses.
3. Flush asserted in the 3rd refill cycle: the next cycle is LOOKUP with all lines invalid; refetching the same address misses again and does a full 4-cycle refill.
4. Reset asserted mid-refill: next cycle stall=0 only after a hit; counters read 0; the previously cached line misses.
5. Force MissCount to all-ones (CountW=4, 16 misses): a further miss leaves it at 4'hF.
6. Ways=1, Sets=4 build: two addresses with the same index thrash; every alternating fetch misses with a 4-cycle stall and OutputIns=NOP while stalled.
